// File: rtl/uart_sim_pkg.sv
// uart_sim_pkg
//   Shared definitions for the simulation UART receiver: FSM state type,
//   8N1 frame constants and the bit-timing helper functions.
package uart_sim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    // Clock cycles per serial bit (integer truncation).
    function automatic int unsigned calc_div(input int unsigned clock_freq,
                                             input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Clock cycles from the start edge to the middle of the start bit.
    function automatic int unsigned calc_half(input int unsigned div);
        return div / 2;
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer
//   Down-counter used to time serial bit sampling points. Loading N-1 makes
//   tick visible to the next clock edge exactly N cycles after the load.
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - asynchronous active-low reset
//     load   - load value into the counter this cycle
//     value  - reload value (N-1 for a tick N cycles later)
//     tick   - counter has reached zero
module uart_rx_bit_timer #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_sim_rx.sv
// uart_sim_rx
//   8N1 UART receiver monitoring a serial TX line. Each correctly framed
//   byte is presented on data_o with a one-cycle valid_o strobe; a low stop
//   bit gives a one-cycle frame_err_o strobe and the byte is dropped.
//   Outside synthesis every received byte is echoed to the console.
//   Ports:
//     clk_i       - system clock, rising edge
//     rstn_i      - asynchronous active-low reset
//     txd_i       - asynchronous serial line, idle high
//     data_o      - last correctly received byte
//     valid_o     - one-cycle strobe, data_o holds a new byte
//     frame_err_o - one-cycle strobe, stop bit sampled low
module uart_sim_rx
    import uart_sim_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100000000,
    parameter int unsigned BAUD_RATE  = 19200
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       txd_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int unsigned DIV   = calc_div(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned HALF  = calc_half(DIV);
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_sim_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end

    rx_state_t              state;
    logic                   sync1;
    logic                   rxs;
    logic                   armed;
    logic [DATA_BITS-1:0]   shreg;
    logic [IDX_W-1:0]       bit_idx;
    logic                   timer_load;
    logic [CNT_W-1:0]       timer_value;
    logic                   tick;

    uart_rx_bit_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .load  (timer_load),
        .value (timer_value),
        .tick  (tick)
    );

    // Timer reloads happen in the same cycle as the matching FSM transition.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = DIV_M1;
        case (state)
            IDLE: begin
                if (armed && !rxs) begin
                    timer_load  = 1'b1;
                    timer_value = HALF_M1;
                end
            end
            START:   timer_load = tick && !rxs;
            DATA:    timer_load = tick;
            default: timer_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1       <= 1'b1;
            rxs         <= 1'b1;
            state       <= IDLE;
            armed       <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            sync1       <= txd_i;
            rxs         <= sync1;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    // Armed only after the line has been seen high, so a
                    // held-low line (break) cannot start a new frame.
                    if (rxs) begin
                        armed <= 1'b1;
                    end
                    if (armed && !rxs) begin
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rxs) begin
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rxs) begin
                            data_o  <= shreg;
                            valid_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                        armed <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rstn_i && valid_o) begin
            if (data_o >= 8'h20 && data_o <= 8'h7e) begin
                $write("%c", data_o);
            end else if (data_o == 8'h0a) begin
                $write("\n");
            end else if (data_o != 8'h0d) begin
                $write("<0x%02h>", data_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_sim_rx.sv
module tb_uart_sim_rx;
    import uart_sim_pkg::*;

    // 1 MHz / 57000 baud -> 17.54, truncated to 17 cycles per bit, half = 8.
    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned BAUD   = 57000;
    localparam int unsigned BIT_T  = 17;
    localparam int unsigned HALF_T = 8;
    localparam int unsigned LAT    = 2 + HALF_T + 9 * BIT_T;

    typedef struct {
        logic [7:0]  data;
        int unsigned t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       txd;
    logic [7:0] data;
    logic       valid;
    logic       ferr;

    int unsigned cyc = 0;
    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          err_pending = 0;
    int          n_valid = 0;
    int          n_ferr = 0;
    logic [7:0]  last_good = 8'h00;
    logic [7:0]  msg [7] = '{8'h4E, 8'h45, 8'h4F, 8'h52, 8'h56, 8'h33, 8'h32};

    uart_sim_rx #(
        .CLOCK_FREQ (CLK_HZ),
        .BAUD_RATE  (BAUD)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .txd_i       (txd),
        .data_o      (data),
        .valid_o     (valid),
        .frame_err_o (ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: sampled on the falling edge.
    always @(negedge clk) begin : mon
        exp_t        e;
        int unsigned lat;
        if (valid || ferr) begin
            total++;
            assert (!(valid && ferr)) else begin
                bad++;
                $error("FAIL both_strobes valid=%b ferr=%b required not both", valid, ferr);
            end
        end
        if (valid) begin
            n_valid++;
            total++;
            assert (q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_valid data=%02h required no pulse", data);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                assert (data === e.data) else begin
                    bad++;
                    $error("FAIL rx_data got=%02h exp=%02h", data, e.data);
                end
                lat = cyc - e.t0;
                total++;
                assert (lat >= LAT - 2 && lat <= LAT + 2) else begin
                    bad++;
                    $error("FAIL rx_latency got=%0d exp=%0d+-2", lat, LAT);
                end
                last_good = e.data;
            end
        end
        if (ferr) begin
            n_ferr++;
            total++;
            assert (err_pending > 0) else begin
                bad++;
                $error("FAIL unexpected_frame_err got=1 exp=0");
            end
            if (err_pending > 0) err_pending--;
            total++;
            assert (data === last_good) else begin
                bad++;
                $error("FAIL ferr_data_kept got=%02h exp=%02h", data, last_good);
            end
        end
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input bit push);
        if (push) q.push_back('{data: b, t0: cyc + 1});
        txd = 1'b0;
        wait_cycles(BIT_T);
        for (int i = 0; i < 8; i++) begin
            txd = b[i];
            wait_cycles(BIT_T);
        end
        txd = stop;
        wait_cycles(BIT_T);
    endtask

    task automatic drain(input int unsigned limit);
        int unsigned n = 0;
        while ((q.size() != 0 || err_pending != 0) && n < limit) begin
            wait_cycles(1);
            n++;
        end
        total++;
        assert (q.size() == 0 && err_pending == 0) else begin
            bad++;
            $error("FAIL drain pending=%0d err_pending=%0d exp=0", q.size(), err_pending);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rstn = 1'b0;
        txd  = 1'b1;
        @(posedge clk);
        #1;
        wait_cycles(5);
        check8("reset_data", data, 8'h00);
        check8("reset_valid", {7'd0, valid}, 8'h00);
        check8("reset_ferr", {7'd0, ferr}, 8'h00);
        rstn = 1'b1;

        // Idle line for 10 bit times
        wait_cycles(10 * BIT_T);
        check_int("idle_valid_count", n_valid, 0);
        check_int("idle_ferr_count", n_ferr, 0);
        check8("idle_data", data, 8'h00);

        // Single byte 'N'
        send_byte(8'h4E, 1'b1, 1'b1);
        drain(4 * BIT_T);
        check8("single_data", data, 8'h4E);
        check_int("single_valid_count", n_valid, 1);

        // "NEORV32" back to back
        for (int i = 0; i < 7; i++) send_byte(msg[i], 1'b1, 1'b1);
        drain(4 * BIT_T);
        check_int("burst_valid_count", n_valid, 8);
        check8("burst_last_data", data, 8'h32);

        // Short low glitch on the idle line
        txd = 1'b0;
        wait_cycles(4);
        txd = 1'b1;
        wait_cycles(HALF_T + 6);
        total++;
        assert (dut.state === IDLE) else begin
            bad++;
            $error("FAIL glitch_state got=%0d exp=%0d", dut.state, IDLE);
        end
        check_int("glitch_valid_count", n_valid, 8);
        check_int("glitch_ferr_count", n_ferr, 0);
        send_byte(8'hA5, 1'b1, 1'b1);
        drain(4 * BIT_T);
        check8("after_glitch_data", data, 8'hA5);

        // Frame error, line held low afterwards
        err_pending = 1;
        send_byte(8'h55, 1'b0, 1'b0);
        wait_cycles(3 * BIT_T);
        drain(4 * BIT_T);
        check_int("ferr_count", n_ferr, 1);
        check_int("ferr_valid_count", n_valid, 9);
        check8("ferr_data_kept", data, 8'hA5);
        txd = 1'b1;
        wait_cycles(2 * BIT_T);
        send_byte(8'h41, 1'b1, 1'b1);
        drain(4 * BIT_T);
        check8("after_ferr_data", data, 8'h41);

        // Reset during data bit 4 of 0xF3 (remaining bits stay high)
        txd = 1'b0;
        wait_cycles(BIT_T);
        for (int i = 0; i < 4; i++) begin
            txd = (8'hF3 >> i) & 8'h01;
            wait_cycles(BIT_T);
        end
        txd = 1'b1;
        wait_cycles(4);
        rstn = 1'b0;
        wait_cycles(2);
        check8("midreset_data", data, 8'h00);
        check8("midreset_valid", {7'd0, valid}, 8'h00);
        check8("midreset_ferr", {7'd0, ferr}, 8'h00);
        last_good = 8'h00;
        rstn = 1'b1;
        wait_cycles(BIT_T - 6 + 4 * BIT_T + 2 * BIT_T);
        check_int("midreset_valid_count", n_valid, 10);
        check_int("midreset_ferr_count", n_ferr, 1);
        send_byte(8'h7E, 1'b1, 1'b1);
        drain(4 * BIT_T);
        check8("after_reset_data", data, 8'h7E);
        check_int("final_valid_count", n_valid, 11);

        wait_cycles(BIT_T);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_sim_rx.md
Name: uart_sim_rx

Overview:
Serial 8N1 UART receiver, used in simulation to monitor the processor's UART0 TX line, e.g. to check the bootloader banner "NEORV32".
- Samples an asynchronous serial line and delivers each received byte on a one-cycle valid strobe.
- In simulation only, echoes each received character to the console.
- Synthesizable core: synchronizer, bit timer, FSM. The print path is excluded from synthesis.

Parameters:
CLOCK_FREQ, 100000000, clock frequency of clk_i in Hz.
BAUD_RATE, 19200, serial bit rate in bit/s.

Ports:
clk_i  input  1  system clock; all logic on rising edge.
rstn_i  input  1  reset, asynchronous, active-low.
txd_i  input  1  serial line under observation (asynchronous, idle high).
data_o  output  8  last correctly received byte.
valid_o  output  1  one-cycle strobe: data_o updated with a new byte.
frame_err_o  output  1  one-cycle strobe: stop bit sampled low, byte discarded.

Behaviour:
- Reset: clk_i, single clock domain; rstn_i asynchronous active-low. During reset:
  - data_o=0x00, valid_o=0, frame_err_o=0.
  - Synchronizer flops = 1, state IDLE, counters/shift register = 0.
- Timing constants:
  - DIV = CLOCK_FREQ/BAUD_RATE, integer truncation (5208 at defaults).
  - HALF = DIV/2 (2604).
  - DIV < 4 is an elaboration error.
- Input path: txd_i passes through a 2-flop synchronizer (rxs). Only rxs is used internally.
- Bit timer: down-counter; "tick" when it reaches 0.
  - Loading value N-1 produces a tick N cycles later.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- FSM states and transitions:
  - IDLE: wait for rxs=0 while armed.
    - Armed = rxs seen high at least one cycle since the last frame end or reset.
    - On start edge: load HALF-1 -> START.
  - START (tick = mid start bit):
    - rxs=0: load DIV-1, bit index=0 -> DATA.
    - rxs=1: glitch -> IDLE, no output.
  - DATA (tick = mid data bit):
    - Shift rxs into shift reg from MSB side (shift right); index+1; load DIV-1.
    - After 8th bit -> STOP.
  - STOP (tick = mid stop bit):
    - rxs=1: data_o <= shift reg, valid_o=1 for exactly one cycle.
    - rxs=0: frame_err_o=1 for exactly one cycle; data_o unchanged.
    - Either case -> IDLE, disarmed until rxs is seen high (no re-trigger on a held-low line/break).
- Latency: valid_o rises HALF + 9*DIV cycles after the start edge reaches rxs, i.e. ~2+2604+46872 cycles after txd_i falls. Verification tolerance ±2 cycles.
- Back-to-back frames: a new start bit directly after the stop bit (stop length 1 bit) must be caught. The receiver re-enters IDLE at mid-stop, leaving half a bit of margin.
- Reset mid-frame: frame aborted immediately, all outputs at reset values. No valid/frame_err pulse until a complete new frame.
- valid_o and frame_err_o are never high in the same cycle.
- Simulation print (translate_off region):
  - On valid_o, $write the character.
  - Bytes 0x20–0x7E printed as-is; 0x0A printed as newline; 0x0D ignored; others printed as "<0xHH>".

Decomposition:
- Shared package uart_sim_pkg: FSM state typedef (IDLE, START, DATA, STOP), frame constants (DATA_BITS=8, STOP_BITS=1), function computing DIV/HALF from the parameters.
- One natural sub-module: uart_rx_bit_timer, holding the down-counter with load/tick interface.
- The synchronizer stays inline.

Test Plan:
- Reset release, line idle high for 10 bit times -> valid_o and frame_err_o stay 0, data_o=0x00.
- Send 0x4E ('N') at 19200 baud, 100 MHz clock -> one valid_o pulse, data_o=0x4E, at ~49478 cycles ±2 after the falling edge; frame_err_o=0.
- Send "NEORV32" back-to-back with 1 stop bit -> seven valid pulses with data 0x4E,0x45,0x4F,0x52,0x56,0x33,0x32 in order; console shows "NEORV32".
- Low glitch of 1000 cycles (< HALF) on the idle line -> no valid, no frame_err, FSM back in IDLE; a following 0xA5 frame is received correctly.
- Frame 0x55 with stop bit forced 0, line held low 3 bit times -> one frame_err_o pulse, data_o keeps its previous value, no spurious frame until the line returns high; a subsequent 0x41 is received.
- Assert rstn_i during data bit 4 of a frame, release mid-frame -> outputs reset, no pulse from the broken frame; the next full frame 0x7E is received correctly.
